// File: rtl/ether_rx_aggregate.sv
// RMII receive path: frame detect, per-byte dibit reorder, 32-bit packing.
// The last complete word of each frame (FCS) is held back and dropped.
module ether_stage (
   input  logic       clk,
   input  logic       rst,
   input  logic       crsdv,
   input  logic [1:0] rxd,
   output logic       ev,
   output logic [1:0] ed
);
   typedef enum logic [1:0] {
      IDLE, PREAMBLE, PAYLOAD, DISCARD
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] pcnt_q, pcnt_d;
   logic       gap_q, gap_d;
   logic       ev_q, ev_d;
   logic [1:0] ed_q, ed_d;

   // gap_q tracks "crsdv was low last cycle" even through reset,
   // so a frame interrupted by reset is discarded until carrier drops.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         pcnt_q  <= 3'd0;
         ev_q    <= 1'b0;
         ed_q    <= 2'b00;
      end else begin
         state_q <= state_d;
         pcnt_q  <= pcnt_d;
         ev_q    <= ev_d;
         ed_q    <= ed_d;
      end
      gap_q <= gap_d;
   end

   always_comb begin
      state_d = state_q;
      pcnt_d  = pcnt_q;
      gap_d   = ~crsdv;
      if (!crsdv) begin
         state_d = IDLE;
         pcnt_d  = 3'd0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (gap_q && rxd == 2'b01) begin
                  state_d = PREAMBLE;
                  pcnt_d  = 3'd1;
               end else begin
                  state_d = DISCARD;
               end
            end
            PREAMBLE: begin
               if (rxd == 2'b01) begin
                  if (pcnt_q != 3'd7)
                     pcnt_d = pcnt_q + 3'd1;
               end else if (rxd == 2'b11 && pcnt_q == 3'd7) begin
                  state_d = PAYLOAD;
                  pcnt_d  = 3'd0;
               end else begin
                  state_d = DISCARD;
                  pcnt_d  = 3'd0;
               end
            end
            PAYLOAD, DISCARD: state_d = state_q;
            default:          state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      ev_d = crsdv && (state_q == PAYLOAD);
      ed_d = ev_d ? rxd : ed_q;
   end

   assign ev = ev_q;
   assign ed = ed_q;
endmodule

module bitorder_stage (
   input  logic       clk,
   input  logic       rst,
   input  logic       iv,
   input  logic [1:0] id,
   output logic       ov,
   output logic [1:0] od
);
   logic [5:0] col_q, col_d;
   logic [1:0] ccnt_q, ccnt_d;
   logic [5:0] buf_q, buf_d;
   logic [1:0] rem_q, rem_d;
   logic       ov_q, ov_d;
   logic [1:0] od_q, od_d;

   always_ff @(posedge clk) begin
      if (!rst) begin
         col_q  <= 6'd0;
         ccnt_q <= 2'd0;
         buf_q  <= 6'd0;
         rem_q  <= 2'd0;
         ov_q   <= 1'b0;
         od_q   <= 2'b00;
      end else begin
         col_q  <= col_d;
         ccnt_q <= ccnt_d;
         buf_q  <= buf_d;
         rem_q  <= rem_d;
         ov_q   <= ov_d;
         od_q   <= od_d;
      end
   end

   // d3 goes straight out; d2..d1..d0 drain from buf over 3 cycles
   always_comb begin
      col_d  = col_q;
      ccnt_d = ccnt_q;
      buf_d  = buf_q;
      rem_d  = rem_q;
      ov_d   = 1'b0;
      od_d   = od_q;
      if (rem_q != 2'd0) begin
         ov_d  = 1'b1;
         od_d  = buf_q[5:4];
         buf_d = {buf_q[3:0], 2'b00};
         rem_d = rem_q - 2'd1;
      end
      if (!iv) begin
         col_d  = 6'd0;
         ccnt_d = 2'd0;
      end else if (ccnt_q == 2'd3) begin
         ov_d   = 1'b1;
         od_d   = id;
         buf_d  = {col_q[1:0], col_q[3:2], col_q[5:4]};
         rem_d  = 2'd3;
         col_d  = 6'd0;
         ccnt_d = 2'd0;
      end else begin
         col_d  = {col_q[3:0], id};
         ccnt_d = ccnt_q + 2'd1;
      end
   end

   assign ov = ov_q;
   assign od = od_q;
endmodule

module aggregate_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        iv,
   input  logic [1:0]  id,
   output logic        axiov,
   output logic [31:0] axiod
);
   logic [31:0] sh_q, sh_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] held_q, held_d;
   logic        have_q, have_d;
   logic        axiov_q, axiov_d;
   logic [31:0] axiod_q, axiod_d;
   logic [31:0] word;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sh_q    <= 32'd0;
         cnt_q   <= 4'd0;
         held_q  <= 32'd0;
         have_q  <= 1'b0;
         axiov_q <= 1'b0;
         axiod_q <= 32'd0;
      end else begin
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         held_q  <= held_d;
         have_q  <= have_d;
         axiov_q <= axiov_d;
         axiod_q <= axiod_d;
      end
   end

   always_comb begin
      word    = {sh_q[29:0], id};
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      held_d  = held_q;
      have_d  = have_q;
      axiov_d = 1'b0;
      axiod_d = axiod_q;
      if (!iv) begin
         sh_d   = 32'd0;
         cnt_d  = 4'd0;
         held_d = 32'd0;
         have_d = 1'b0;
      end else if (cnt_q == 4'd15) begin
         // release previous word only once a successor exists
         sh_d   = 32'd0;
         cnt_d  = 4'd0;
         held_d = word;
         have_d = 1'b1;
         if (have_q) begin
            axiov_d = 1'b1;
            axiod_d = held_q;
         end
      end else begin
         sh_d  = word;
         cnt_d = cnt_q + 4'd1;
      end
   end

   assign axiov = axiov_q;
   assign axiod = axiod_q;
endmodule

module ether_rx_aggregate (
   input  logic        clk,
   input  logic        rst,
   input  logic        crsdv,
   input  logic [1:0]  rxd,
   output logic        axiov,
   output logic [31:0] axiod
);
   logic       e_v;
   logic [1:0] e_d;
   logic       b_v;
   logic [1:0] b_d;

   ether_stage u_ether (
      .clk   (clk),
      .rst   (rst),
      .crsdv (crsdv),
      .rxd   (rxd),
      .ev    (e_v),
      .ed    (e_d)
   );

   bitorder_stage u_bitorder (
      .clk (clk),
      .rst (rst),
      .iv  (e_v),
      .id  (e_d),
      .ov  (b_v),
      .od  (b_d)
   );

   aggregate_stage u_aggregate (
      .clk   (clk),
      .rst   (rst),
      .iv    (b_v),
      .id    (b_d),
      .axiov (axiov),
      .axiod (axiod)
   );
endmodule

// File: tb/tb_ether_rx_aggregate.sv
// Bench for ether_rx_aggregate: directed frames plus random frames
// scored against a frame-level parse of the dibit stream.
module tb_ether_rx_aggregate;
   typedef logic [1:0] dq_t[$];

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        crsdv = 1'b0;
   logic [1:0]  rxd = 2'b00;
   logic        axiov;
   logic [31:0] axiod;

   int checks = 0;
   int failures = 0;
   int exp_n = 0;
   int obs_n = 0;
   logic [31:0] exp_q[$];

   bit          v_prev = 1'b0;
   bit          rst_prev = 1'b0;
   logic [31:0] d_prev = 32'd0;

   ether_rx_aggregate dut (
      .clk   (clk),
      .rst   (rst),
      .crsdv (crsdv),
      .rxd   (rxd),
      .axiov (axiov),
      .axiod (axiod)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_prev) begin
         if (axiov) begin
            chk("v_gap", {31'd0, v_prev}, 32'd0);
            chk("pulse_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0)
               chk("word", axiod, exp_q.pop_front());
            obs_n++;
         end else begin
            chk("hold_d", axiod, d_prev);
         end
      end
      v_prev   = axiov;
      d_prev   = axiod;
      rst_prev = rst;
   end

   // Frame-level reference: validate preamble/SFD, pack bytes LSB
   // dibit first, bytes big-endian into words, drop the last word.
   function automatic void model(input dq_t f);
      int st;
      int cnt;
      bit bad;
      logic [7:0]  by[$];
      logic [31:0] w[$];
      st  = -1;
      bad = 1'b0;
      if (f.size() == 0 || f[0] != 2'b01) return;
      cnt = 1;
      for (int i = 1; i < f.size(); i++) begin
         if (st < 0 && !bad) begin
            if (f[i] == 2'b01) cnt++;
            else if (f[i] == 2'b11 && cnt >= 7) st = i + 1;
            else bad = 1'b1;
         end
      end
      if (st < 0) return;
      for (int k = st; k + 3 < f.size(); k += 4)
         by.push_back({f[k+3], f[k+2], f[k+1], f[k]});
      for (int k = 0; k + 3 < by.size(); k += 4)
         w.push_back({by[k], by[k+1], by[k+2], by[k+3]});
      for (int k = 0; k + 1 < w.size(); k++) begin
         exp_q.push_back(w[k]);
         exp_n++;
      end
   endfunction

   function automatic dq_t rep(input dq_t f, input int n,
                               input logic [1:0] d);
      dq_t r;
      r = f;
      for (int i = 0; i < n; i++) r.push_back(d);
      return r;
   endfunction

   function automatic dq_t f023();
      dq_t f;
      logic [1:0] tail[16];
      tail = '{2'b01, 2'b00, 2'b00, 2'b11, 2'b01, 2'b01, 2'b00, 2'b11,
               2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b10, 2'b11, 2'b00};
      f = rep(f, 31, 2'b01);
      f = rep(f, 1, 2'b11);
      f = rep(f, 24, 2'b11);
      f = rep(f, 24, 2'b01);
      f = rep(f, 8, 2'b00);
      for (int i = 0; i < 16; i++) f.push_back(tail[i]);
      f = rep(f, 16, 2'b00);
      return f;
   endfunction

   function automatic void exp023();
      exp_q.push_back(32'hFFFFFFFF);
      exp_q.push_back(32'hFFFF5555);
      exp_q.push_back(32'h55555555);
      exp_q.push_back(32'h0000C1C5);
      exp_n += 4;
   endfunction

   task automatic send(input dq_t f, input int gap, input int rst_at);
      for (int i = 0; i < f.size(); i++) begin
         @(posedge clk);
         #1;
         crsdv = 1'b1;
         rxd   = f[i];
         rst   = (i == rst_at) ? 1'b0 : 1'b1;
      end
      for (int i = 0; i < gap; i++) begin
         @(posedge clk);
         #1;
         crsdv = 1'b0;
         rxd   = 2'b00;
         rst   = 1'b1;
      end
   endtask

   task automatic settle(input string tag, input int o0, input int e0);
      repeat (16) @(posedge clk);
      @(negedge clk);
      chk({tag, "_pulses"}, obs_n - o0, exp_n - e0);
      chk({tag, "_drain"}, exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      dq_t f;
      int  o0;
      int  e0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_axiov", {31'd0, axiov}, 32'd0);
      chk("rst_axiod", axiod, 32'd0);
      #1 rst = 1'b1;

      o0 = obs_n; e0 = exp_n;
      exp023();
      send(f023(), 8, -1);
      settle("req023", o0, e0);

      o0 = obs_n; e0 = exp_n;
      f = {};
      f = rep(f, 16, 2'b10);
      f = rep(f, 16, 2'b11);
      f = rep(f, 16, 2'b01);
      f = rep(f, 16, 2'b00);
      send(f, 4, -1);
      settle("no_pre", o0, e0);

      o0 = obs_n; e0 = exp_n;
      f = {};
      f = rep(f, 5, 2'b01);
      f = rep(f, 1, 2'b11);
      for (int i = 0; i < 32; i++) f.push_back(2'($urandom));
      send(f, 4, -1);
      settle("short_pre", o0, e0);

      o0 = obs_n; e0 = exp_n;
      f = {};
      f = rep(f, 31, 2'b01);
      f = rep(f, 1, 2'b11);
      for (int i = 0; i < 32; i++) f.push_back(2'($urandom));
      model(f);
      chk("fcs_model_n", exp_n - e0, 32'd1);
      send(f, 4, -1);
      settle("fcs", o0, e0);

      o0 = obs_n; e0 = exp_n;
      send(f023(), 1, 40);
      exp023();
      send(f023(), 8, -1);
      settle("mid_rst", o0, e0);

      o0 = obs_n; e0 = exp_n;
      exp023();
      exp023();
      send(f023(), 1, -1);
      send(f023(), 8, -1);
      settle("b2b", o0, e0);

      o0 = obs_n; e0 = exp_n;
      for (int n = 0; n < 25; n++) begin
         f = {};
         if ($urandom_range(0, 9) == 0) f.push_back(2'($urandom));
         else f.push_back(2'b01);
         f = rep(f, $urandom_range(0, 14), 2'b01);
         if ($urandom_range(0, 7) == 0) f.push_back(2'($urandom));
         f.push_back(2'b11);
         for (int i = 0; i < $urandom_range(0, 140); i++)
            f.push_back(2'($urandom));
         model(f);
         send(f, $urandom_range(1, 3), -1);
      end
      settle("rand", o0, e0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
